// File: rtl/vgc_timing.sv
// ---------------------------------------------------------------------------
// vgc_timing - raster timing generator feeding the VGC pixel/fetch stage.
//
// Divides clk_vid into the pixel enable ce_pix, runs the H/V raster counters,
// registers the sync/blank/VBL decodes and produces frame-derived ticks for
// the interrupt block plus a coherent H/V snapshot for CPU readback.
//
// Ports:
//   clk_vid    in   1   video clock
//   reset      in   1   synchronous, active-high reset
//   ce_pix     out  1   pixel enable, one clk_vid cycle every CE_DIV
//   H          out  10  horizontal pixel counter
//   V          out  9   vertical line counter
//   hsync      out  1   active-high horizontal sync
//   vsync      out  1   active-high vertical sync
//   hblank     out  1   H >= H_VIS
//   vblank     out  1   V >= V_VIS
//   vbl_status out  1   V >= VBL_LINE
//   frame_cnt  out  8   free-running frame counter
//   qsec_tick  out  1   one-cycle quarter-second pulse
//   sec_tick   out  1   one-cycle one-second pulse
//   snap_req   in   1   one-cycle CPU counter-latch request
//   snap_H     out  10  latched H
//   snap_V     out  9   latched V
//   snap_valid out  1   one-cycle pulse when snap_H/snap_V are updated
// ---------------------------------------------------------------------------
module vgc_timing #(
    parameter int CE_DIV          = 2,
    parameter int H_TOTAL         = 914,
    parameter int V_TOTAL         = 262,
    parameter int H_VIS           = 704,
    parameter int V_VIS           = 224,
    parameter int HS_START        = 736,
    parameter int HS_WIDTH        = 64,
    parameter int VS_START        = 234,
    parameter int VS_WIDTH        = 3,
    parameter int VBL_LINE        = 208,
    parameter int FRAMES_PER_QSEC = 15
) (
    input  logic       clk_vid,
    input  logic       reset,
    output logic       ce_pix,
    output logic [9:0] H,
    output logic [8:0] V,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       vbl_status,
    output logic [7:0] frame_cnt,
    output logic       qsec_tick,
    output logic       sec_tick,
    input  logic       snap_req,
    output logic [9:0] snap_H,
    output logic [8:0] snap_V,
    output logic       snap_valid
);

    localparam int DIV_W = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;
    localparam int Q_W   = (FRAMES_PER_QSEC > 2) ? $clog2(FRAMES_PER_QSEC) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(FRAMES_PER_QSEC - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [8:0]       V_LAST   = 9'(V_TOTAL - 1);

    // Half-open window test [lo, lo+width) done in int so lo+width cannot wrap.
    function automatic logic in_window(input int val, input int lo, input int width);
        return (val >= lo) && (val < lo + width);
    endfunction

    logic [DIV_W-1:0] r_div;
    logic             r_ce;
    logic [9:0]       r_h;
    logic [8:0]       r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblank;
    logic             r_vblank;
    logic             r_vbl;
    logic [7:0]       r_frame;
    logic [Q_W-1:0]   r_qcnt;
    logic [1:0]       r_scnt;
    logic             r_qsec;
    logic             r_sec;
    logic [9:0]       r_snap_h;
    logic [8:0]       r_snap_v;
    logic             r_snap_valid;

    logic       w_div_last;
    logic       w_h_wrap;
    logic       w_v_wrap;
    logic [9:0] w_h_next;
    logic [8:0] w_v_next;
    logic       w_frame_wrap;
    logic       w_q_wrap;
    logic       w_hsync_next;
    logic       w_vsync_next;
    logic       w_hblank_next;
    logic       w_vblank_next;
    logic       w_vbl_next;

    // Next raster position, wrap detection and decodes of the next position.
    always_comb begin
        w_div_last   = (r_div == DIV_LAST);
        w_h_wrap     = (r_h == H_LAST);
        w_v_wrap     = (r_v == V_LAST);
        w_h_next     = 10'd0;
        w_v_next     = r_v;
        if (w_h_wrap) begin
            w_h_next = 10'd0;
            if (w_v_wrap) begin
                w_v_next = 9'd0;
            end else begin
                w_v_next = r_v + 9'd1;
            end
        end else begin
            w_h_next = r_h + 10'd1;
            w_v_next = r_v;
        end
        w_frame_wrap  = r_ce & w_h_wrap & w_v_wrap;
        w_q_wrap      = (r_qcnt == Q_LAST);
        w_hsync_next  = in_window(int'(w_h_next), HS_START, HS_WIDTH);
        w_vsync_next  = in_window(int'(w_v_next), VS_START, VS_WIDTH);
        w_hblank_next = (int'(w_h_next) >= H_VIS);
        w_vblank_next = (int'(w_v_next) >= V_VIS);
        w_vbl_next    = (int'(w_v_next) >= VBL_LINE);
    end

    // Pixel-enable divider; ce_pix is high the cycle after the divider's last count.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_div <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_div <= w_div_last ? '0 : r_div + DIV_W'(1);
            r_ce  <= w_div_last;
        end
    end

    // Raster counters and their decodes, all updated together on ce_pix.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_h      <= 10'd0;
            r_v      <= 9'd0;
            r_hsync  <= 1'b0;
            r_vsync  <= 1'b0;
            r_hblank <= 1'b0;
            r_vblank <= 1'b0;
            r_vbl    <= 1'b0;
        end else if (r_ce) begin
            r_h      <= w_h_next;
            r_v      <= w_v_next;
            r_hsync  <= w_hsync_next;
            r_vsync  <= w_vsync_next;
            r_hblank <= w_hblank_next;
            r_vblank <= w_vblank_next;
            r_vbl    <= w_vbl_next;
        end
    end

    // Frame counter and quarter/second tick chain; ticks share the frame_cnt update edge.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_frame <= 8'd0;
            r_qcnt  <= '0;
            r_scnt  <= 2'd0;
            r_qsec  <= 1'b0;
            r_sec   <= 1'b0;
        end else begin
            r_qsec <= w_frame_wrap & w_q_wrap;
            r_sec  <= w_frame_wrap & w_q_wrap & (r_scnt == 2'd3);
            if (w_frame_wrap) begin
                r_frame <= r_frame + 8'd1;
                r_qcnt  <= w_q_wrap ? '0 : r_qcnt + Q_W'(1);
                if (w_q_wrap) begin
                    r_scnt <= r_scnt + 2'd1;
                end
            end
        end
    end

    // CPU snapshot: captures the H/V visible in the request cycle (pre-update value).
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            r_snap_h     <= 10'd0;
            r_snap_v     <= 9'd0;
            r_snap_valid <= 1'b0;
        end else begin
            r_snap_valid <= snap_req;
            if (snap_req) begin
                r_snap_h <= r_h;
                r_snap_v <= r_v;
            end
        end
    end

    assign ce_pix     = r_ce;
    assign H          = r_h;
    assign V          = r_v;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign hblank     = r_hblank;
    assign vblank     = r_vblank;
    assign vbl_status = r_vbl;
    assign frame_cnt  = r_frame;
    assign qsec_tick  = r_qsec;
    assign sec_tick   = r_sec;
    assign snap_H     = r_snap_h;
    assign snap_V     = r_snap_v;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_vgc_timing.sv
// ---------------------------------------------------------------------------
// tb_vgc_timing - self-checking bench for vgc_timing.
// The line keeps its full 914 pixels; the frame is shortened to 4 lines and a
// quarter-second to 2 frames so that whole-frame and tick behaviour fits in a
// short run. The reference model derives every output from the number of
// clocks since the last reset using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_vgc_timing;

    localparam int CE  = 2;
    localparam int HT  = 914;
    localparam int VT  = 4;
    localparam int HV  = 704;
    localparam int VV  = 3;
    localparam int HSS = 736;
    localparam int HSW = 64;
    localparam int VSS = 2;
    localparam int VSW = 1;
    localparam int VBL = 1;
    localparam int FPQ = 2;

    logic       clk_vid;
    logic       reset;
    logic       snap_req;
    logic       ce_pix;
    logic [9:0] H;
    logic [8:0] V;
    logic       hsync, vsync, hblank, vblank, vbl_status;
    logic [7:0] frame_cnt;
    logic       qsec_tick, sec_tick;
    logic [9:0] snap_H;
    logic [8:0] snap_V;
    logic       snap_valid;

    vgc_timing #(
        .CE_DIV(CE), .H_TOTAL(HT), .V_TOTAL(VT), .H_VIS(HV), .V_VIS(VV),
        .HS_START(HSS), .HS_WIDTH(HSW), .VS_START(VSS), .VS_WIDTH(VSW),
        .VBL_LINE(VBL), .FRAMES_PER_QSEC(FPQ)
    ) dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .H(H), .V(V),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .vbl_status(vbl_status), .frame_cnt(frame_cnt), .qsec_tick(qsec_tick),
        .sec_tick(sec_tick), .snap_req(snap_req), .snap_H(snap_H),
        .snap_V(snap_V), .snap_valid(snap_valid)
    );

    initial begin
        clk_vid = 1'b0;
        forever #5 clk_vid = ~clk_vid;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_k    = 0;     // clocks since the last clock with reset high
    logic       m_live = 1'b0;
    int         m_snap_h = 0;
    int         m_snap_v = 0;
    int         m_snap_valid = 0;

    // Pixel advances completed after k clocks: ce_pix is high after clocks
    // CE, 2CE, ... and each high cycle advances the raster on the next clock.
    function automatic int pix_of(input int k);
        return (k <= 0) ? 0 : (k - 1) / CE;
    endfunction

    function automatic int h_of(input int k);
        return pix_of(k) % HT;
    endfunction

    function automatic int v_of(input int k);
        return (pix_of(k) / HT) % VT;
    endfunction

    function automatic int frames_of(input int k);
        return pix_of(k) / (HT * VT);
    endfunction

    function automatic int b2i(input logic b);
        return b ? 1 : 0;
    endfunction

    always @(posedge clk_vid) begin
        if (reset) begin
            m_live       <= 1'b1;
            m_k          <= 0;
            m_snap_h     <= 0;
            m_snap_v     <= 0;
            m_snap_valid <= 0;
        end else begin
            m_k <= m_k + 1;
            if (snap_req) begin
                m_snap_h     <= h_of(m_k);
                m_snap_v     <= v_of(m_k);
                m_snap_valid <= 1;
            end else begin
                m_snap_valid <= 0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk_vid) begin
        if (m_live) begin
            int eh, ev, efr, new_pix, fstart, eq, es;
            eh      = h_of(m_k);
            ev      = v_of(m_k);
            efr     = frames_of(m_k);
            new_pix = (m_k >= 1 && pix_of(m_k) != pix_of(m_k - 1)) ? 1 : 0;
            fstart  = (new_pix == 1 && eh == 0 && ev == 0) ? 1 : 0;
            eq      = (fstart == 1 && (efr % FPQ) == 0) ? 1 : 0;
            es      = (eq == 1 && ((efr / FPQ) % 4) == 0) ? 1 : 0;
            check("ce_pix", b2i(ce_pix), (m_k >= CE && (m_k % CE) == 0) ? 1 : 0);
            check("H", int'(H), eh);
            check("V", int'(V), ev);
            check("hsync", b2i(hsync), (eh >= HSS && eh < HSS + HSW) ? 1 : 0);
            check("vsync", b2i(vsync), (ev >= VSS && ev < VSS + VSW) ? 1 : 0);
            check("hblank", b2i(hblank), (eh >= HV) ? 1 : 0);
            check("vblank", b2i(vblank), (ev >= VV) ? 1 : 0);
            check("vbl_status", b2i(vbl_status), (ev >= VBL) ? 1 : 0);
            check("frame_cnt", int'(frame_cnt), efr % 256);
            check("qsec_tick", b2i(qsec_tick), eq);
            check("sec_tick", b2i(sec_tick), es);
            check("snap_H", int'(snap_H), m_snap_h);
            check("snap_V", int'(snap_V), m_snap_v);
            check("snap_valid", b2i(snap_valid), m_snap_valid);
        end
    end

    // Event tallies used by the literal checks (differences taken in main).
    int hs_pix = 0, hb_pix = 0, q_cnt = 0, s_cnt = 0, last_q_frame = 0, s_frame = 0;
    always @(negedge clk_vid) begin
        if (ce_pix && V == 9'd0 && hsync)  hs_pix <= hs_pix + 1;
        if (ce_pix && V == 9'd0 && hblank) hb_pix <= hb_pix + 1;
        if (qsec_tick) begin
            q_cnt        <= q_cnt + 1;
            last_q_frame <= int'(frame_cnt);
        end
        if (sec_tick) begin
            s_cnt   <= s_cnt + 1;
            s_frame <= int'(frame_cnt);
        end
    end

    task automatic step();
        @(posedge clk_vid);
        #2;
    endtask

    task automatic check_restart();
        step();
        check("lit_ce_k1", b2i(ce_pix), 0);
        step();
        check("lit_ce_k2", b2i(ce_pix), 1);
        check("lit_h_k2", int'(H), 0);
        step();
        check("lit_ce_k3", b2i(ce_pix), 0);
        check("lit_h_k3", int'(H), 1);
    endtask

    initial begin
        int hs0, hb0, found;
        reset    = 1'b1;
        snap_req = 1'b0;
        repeat (5) @(posedge clk_vid);
        #2;
        check("lit_reset_h", int'(H), 0);
        check("lit_reset_frame", int'(frame_cnt), 0);
        check("lit_reset_ce", b2i(ce_pix), 0);
        reset = 1'b0;
        hs0 = hs_pix;
        hb0 = hb_pix;
        check_restart();

        // One full line.
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (V == 9'd1) begin found = 1; break; end
        end
        check("lit_line_wrap_seen", found, 1);
        check("lit_h_at_line_wrap", int'(H), 0);
        check("lit_hsync_pixels", hs_pix - hs0, 64);
        check("lit_hblank_pixels", hb_pix - hb0, 210);

        // Snapshot around the 911 -> 912 update.
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            if (H == 10'd911 && ce_pix) begin found = 1; break; end
            step();
        end
        check("lit_snap_slot_seen", found, 1);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("lit_snap1_valid", b2i(snap_valid), 1);
        check("lit_snap1_h", int'(snap_H), 911);
        check("lit_snap1_v", int'(snap_V), 1);
        step();
        snap_req = 1'b1;
        check("lit_snap_gap_valid", b2i(snap_valid), 0);
        step();
        check("lit_snap2_valid", b2i(snap_valid), 1);
        check("lit_snap2_h", int'(snap_H), 912);
        step();
        snap_req = 1'b0;
        check("lit_snap3_valid", b2i(snap_valid), 1);
        check("lit_snap3_h", int'(snap_H), 913);
        step();
        check("lit_snap_end_valid", b2i(snap_valid), 0);

        // Eight frames: four quarter ticks, one second tick.
        found = 0;
        for (int i = 0; i < 9 * CE * HT * VT; i++) begin
            step();
            if (frame_cnt == 8'd8) begin found = 1; break; end
        end
        check("lit_frame8_seen", found, 1);
        step();
        check("lit_qsec_count", q_cnt, 4);
        check("lit_last_qsec_frame", last_q_frame, 8);
        check("lit_sec_count", s_cnt, 1);
        check("lit_sec_frame", s_frame, 8);

        // Mid-frame reset with a simultaneous snapshot request.
        found = 0;
        for (int i = 0; i < 2 * CE * HT * VT; i++) begin
            if (H == 10'd500 && V == 9'd2) begin found = 1; break; end
            step();
        end
        check("lit_midframe_seen", found, 1);
        reset    = 1'b1;
        snap_req = 1'b1;
        step();
        reset    = 1'b0;
        snap_req = 1'b0;
        check("lit_rst_h", int'(H), 0);
        check("lit_rst_v", int'(V), 0);
        check("lit_rst_frame", int'(frame_cnt), 0);
        check("lit_rst_snap_valid", b2i(snap_valid), 0);
        check("lit_rst_snap_h", int'(snap_H), 0);
        check_restart();
        repeat (2000) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
